// File: rtl/countdown_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : countdown_seq_ctrl
// Brief    : Sequencing controller for a synchronous WIDTH-bit down counter.
//            Loads a start value on command and decrements it at a
//            programmable prescaled rate. Supports pause/resume and abort,
//            and flags the terminal count with a one-cycle done pulse.
// Options  : COUNTDOWN_AUTO_RELOAD_EN - when defined, the terminal tick
//            reloads the latched start value and keeps counting until an
//            abort. done then pulses in the same cycle as that tick.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_seq_ctrl #(
    parameter int WIDTH   = 3,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,      // asynchronous, active low
    input  logic [WIDTH-1:0]   load_val,
    input  logic [PRESC_W-1:0] presc_div,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   Q,
    output logic               busy,
    output logic               tick,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0]   C_Q_ONE     = WIDTH'(1);
    localparam logic [PRESC_W-1:0] C_PRESC_ONE = PRESC_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] div_q, div_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0]   reload_q, reload_d;
`endif

    logic w_at_div;
    logic w_tick;
    logic w_last;

    // Tick fires only on a real decrement: abort and pause both pre-empt it.
    always_comb begin
        w_at_div = (presc_q == div_q);
        w_tick   = (state_q == S_RUN) && !abort && !pause && w_at_div;
        w_last   = (q_q == C_Q_ONE);
    end

    // Next-state and datapath decisions for the sequencer.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        presc_d  = presc_q;
        div_d    = div_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d      = load_val;
                    div_d    = presc_div;
                    presc_d  = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_d = load_val;
`endif
                    // A zero start value has nothing to count: finish at once.
                    state_d  = (load_val == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    q_d     = '0;
                    presc_d = '0;
                end else if (pause) begin
                    // Prescaler and count freeze; resume keeps the phase.
                    state_d = S_HOLD;
                end else if (w_at_div) begin
                    presc_d = '0;
                    if (w_last) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        q_d     = reload_q;
`else
                        q_d     = '0;
                        state_d = S_DONE;
`endif
                    end else begin
                        q_d = q_q - C_Q_ONE;
                    end
                end else begin
                    presc_d = presc_q + C_PRESC_ONE;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    q_d     = '0;
                    presc_d = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                // Single-cycle terminal state; start is not looked at here.
                q_d     = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                q_d     = '0;
                presc_d = '0;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and registered Moore outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            q_q      <= '0;
            presc_q  <= '0;
            div_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            presc_q  <= presc_d;
            div_q    <= div_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // Output drive.
    always_comb begin
        Q    = q_q;
        busy = busy_q;
        tick = w_tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // In reload mode the terminal tick never visits DONE, so the pulse
        // is raised alongside the tick that performs the reload.
        done = done_q || (w_tick && w_last);
`else
        done = done_q;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_countdown_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_seq_ctrl
// Brief    : Self-checking bench for countdown_seq_ctrl with a behavioural
//            countdown model, directed scenarios and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_seq_ctrl;

    localparam int WIDTH   = 3;
    localparam int PRESC_W = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [WIDTH-1:0]   load_val = '0;
    logic [PRESC_W-1:0] presc_div = '0;
    logic               start = 1'b0;
    logic               pause = 1'b0;
    logic               abort = 1'b0;
    logic [WIDTH-1:0]   Q;
    logic               busy;
    logic               tick;
    logic               done;

    countdown_seq_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_val  (load_val),
        .presc_div (presc_div),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .Q         (Q),
        .busy      (busy),
        .tick      (tick),
        .done      (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycles = 0;

    // Behavioural model: a countdown that is either idle, counting (maybe
    // held), or showing its one-cycle finished flag.
    int m_q      = 0;
    int m_phase  = 0;
    int m_div    = 0;
    int m_reload = 0;
    bit m_counting = 0;
    bit m_held     = 0;
    bit m_finished = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_phase = 0; m_div = 0; m_reload = 0;
        m_counting = 0; m_held = 0; m_finished = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, take the edge.
    task automatic step(input bit s, input bit p, input bit a, input int lv, input int dv);
        bit t_exp;
        bit d_exp;
        logic [31:0] lv_v;
        logic [31:0] dv_v;
        lv_v = lv;
        dv_v = dv;
        start = s; pause = p; abort = a;
        load_val  = lv_v[WIDTH-1:0];
        presc_div = dv_v[PRESC_W-1:0];
        #1;
        t_exp = m_counting && !m_held && !p && !a && (m_phase == m_div);
        d_exp = m_finished;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (t_exp && m_q == 1) d_exp = 1'b1;
`endif
        check("Q",    32'(Q),    m_q);
        check("busy", 32'(busy), 32'(m_counting));
        check("tick", 32'(tick), 32'(t_exp));
        check("done", 32'(done), 32'(d_exp));
        @(posedge clk);
        cycles++;
        if (m_finished) begin
            m_finished = 0;
            m_q = 0;
        end else if (!m_counting) begin
            if (s) begin
                m_div = dv % (1 << PRESC_W);
                m_phase = 0;
                m_q = lv % (1 << WIDTH);
                m_reload = m_q;
                if (m_q == 0) m_finished = 1;
                else begin m_counting = 1; m_held = 0; end
            end
        end else if (a) begin
            m_counting = 0; m_held = 0; m_q = 0; m_phase = 0;
        end else if (p) begin
            m_held = 1;
        end else if (m_held) begin
            m_held = 0;
        end else if (m_phase == m_div) begin
            m_phase = 0;
            m_q = m_q - 1;
            if (m_q == 0) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                m_q = m_reload;
`else
                m_counting = 0;
                m_finished = 1;
`endif
            end
        end else begin
            m_phase = m_phase + 1;
        end
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Start a countdown and measure edges until done is seen, bounded.
    task automatic timed_run(input string tag, input int lv, input int dv, input int exp_len);
        int c0;
        int n;
        step(1, 0, 0, lv, dv);
        c0 = cycles;
        n = 0;
        while (done !== 1'b1 && n < 400) begin
            step(0, 0, 0, 0, 0);
            n++;
        end
        check(tag, cycles - c0, exp_len);
    endtask

    initial begin
        // Reset values while reset is held.
        #3;
        check("rst_Q",    32'(Q),    0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_done", 32'(done), 0);
        #9 reset = 1'b1;
        @(posedge clk); cycles++;
        #2;
        model_reset();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Reload sequence 3,2,1,3,2,1 with done on each reload tick.
        step(1, 0, 0, 3, 0);
        for (int i = 0; i < 9; i++) begin
            check("ar_seq_q", 32'(Q), 3 - (i % 3));
            step(0, 0, 0, 0, 0);
        end
        check("ar_busy", 32'(busy), 1);
        step(0, 0, 1, 0, 0);
        check("ar_abort_q", 32'(Q), 0);
        check("ar_abort_busy", 32'(busy), 0);
        idle(3);
`else
        // One-shot, divisor 0: Q 5,4,3,2,1,0 on consecutive cycles.
        step(1, 0, 0, 5, 0);
        check("os_start_q", 32'(Q), 5);
        for (int v = 4; v >= 0; v--) begin
            step(0, 0, 0, 0, 0);
            check("os_seq_q", 32'(Q), v);
        end
        check("os_done",  32'(done), 1);
        check("os_busy",  32'(busy), 0);
        step(0, 0, 0, 0, 0);
        check("os_done_drop", 32'(done), 0);

        // Prescaled run with an ignored start pulse in the middle.
        begin
            int c0;
            int n;
            step(1, 0, 0, 2, 3);
            c0 = cycles;
            step(0, 0, 0, 0, 0);
            step(1, 0, 0, 7, 0);
            n = 0;
            while (done !== 1'b1 && n < 100) begin
                step(0, 0, 0, 0, 0);
                n++;
            end
            check("presc_len", cycles - c0, 8);
        end
        idle(2);

        // Pause after the second tick, resume, then abort at Q=3.
        begin
            int n;
            step(1, 0, 0, 7, 1);
            n = 0;
            while (m_q != 5 && n < 50) begin step(0, 0, 0, 0, 0); n++; end
            for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
            check("pause_q", 32'(Q), 5);
            n = 0;
            while (m_q != 3 && n < 50) begin step(0, 0, 0, 0, 0); n++; end
            check("pre_abort_q", 32'(Q), 3);
            step(0, 0, 1, 0, 0);
            check("abort_q",    32'(Q),    0);
            check("abort_busy", 32'(busy), 0);
            check("abort_done", 32'(done), 0);
            idle(3);
            step(1, 0, 0, 6, 2);
            idle(2);
            step(0, 1, 1, 0, 0);
            check("abort_pause_busy", 32'(busy), 0);
            check("abort_pause_q",    32'(Q),    0);
            idle(2);
        end

        // Zero start value: done on the next cycle, never busy.
        timed_run("zero_len", 0, 5, 0);
        check("zero_busy", 32'(busy), 0);
        idle(2);

        // Maximum value and divisor: 7 * 16 cycles.
        timed_run("max_len", 7, 15, 112);
        idle(2);
`endif

        // Asynchronous reset mid-count at Q=3.
        step(1, 0, 0, 5, 0);
        idle(2);
        check("pre_rst_q", 32'(Q), 3);
        reset = 1'b0;
        #1;
        check("mid_rst_Q",    32'(Q),    0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_tick", 32'(tick), 0);
        check("mid_rst_done", 32'(done), 0);
        model_reset();
        @(posedge clk); cycles++;
        #2 reset = 1'b1;
        @(posedge clk); cycles++;
        #2;
        // Idle block ignores pause and abort.
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 20) == 0,
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
